hazard_mode_sched: RTL and testbench

- Scheduler that shares the hazard-light pattern generator between three requesters: emergency, left-wind and right-wind.
- Arbitrates the requesters and drives the generator's 2-bit mode code.
- Produces the step pulse (clock enable) that paces the generator, and enforces a minimum dwell per grant so a mode cannot flicker.
- Sits between the raw switch or request inputs and the pattern FSM.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_mode_sched_sync2.sv | 25 ++
 rtl/hazard_mode_sched.sv | 156 +++++++++++++++
 tb/tb_hazard_mode_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard-light mode scheduler.
// Mode codes feed the pattern generator; grant bit positions index the one-hot owner.
package hazard_pkg;

  localparam logic [1:0] MODE_HAZ   = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;

  localparam int GNT_EMERG = 2;
  localparam int GNT_LEFT  = 1;
  localparam int GNT_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    DWELL = 2'b10
  } state_t;

  // Emergency owner and idle both map to the hazard pattern; code 11 is unreachable.
  function automatic logic [1:0] mode_of(input logic [2:0] owner);
    logic [1:0] m;
    case (owner)
      3'b010:  m = MODE_LEFT;
      3'b001:  m = MODE_RIGHT;
      default: m = MODE_HAZ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hazard_mode_sched_sync2.sv
// Two-flop synchronizer for one asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // two-stage capture of the asynchronous level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/hazard_mode_sched.sv
// Arbitrates emergency/left/right requests onto the shared hazard pattern generator,
// paces it with a step pulse and holds each grant for a minimum number of steps.
module hazard_mode_sched
  import hazard_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int MIN_DWELL = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_emerg,
  input  logic       req_left,
  input  logic       req_right,
  output logic [1:0] mode,
  output logic       step,
  output logic [2:0] grant,
  output logic       busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL);

  logic          emerg_s;
  logic          left_s;
  logic          right_s;
  logic          own_req_s;
  logic          wrap_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [2:0]    grant_r;
  logic [2:0]    grant_nxt_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic [DW-1:0] dwell_r;
  logic [DW-1:0] dwell_nxt_s;
  logic          rr_left_r;
  logic          rr_nxt_s;
  logic          step_r;
  logic          step_nxt_s;
  logic [1:0]    mode_r;
  logic          busy_r;

  sync2 u_sync_emerg (.clk(clk), .reset(reset), .d(req_emerg), .q(emerg_s));
  sync2 u_sync_left  (.clk(clk), .reset(reset), .d(req_left),  .q(left_s));
  sync2 u_sync_right (.clk(clk), .reset(reset), .d(req_right), .q(right_s));

  // arbitration, prescaler, dwell counter and next-state decision
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    presc_nxt_s = presc_r;
    dwell_nxt_s = dwell_r;
    rr_nxt_s    = rr_left_r;
    step_nxt_s  = 1'b0;
    own_req_s   = (grant_r[GNT_EMERG] & emerg_s) |
                  (grant_r[GNT_LEFT]  & left_s)  |
                  (grant_r[GNT_RIGHT] & right_s);
    wrap_s      = (presc_r == PRESC_LAST);

    case (state_r)
      IDLE: begin
        presc_nxt_s = '0;
        dwell_nxt_s = '0;
        grant_nxt_s = 3'b000;
        if (emerg_s) begin
          state_nxt_s            = GRANT;
          grant_nxt_s[GNT_EMERG] = 1'b1;
        end else if (left_s && right_s) begin
          state_nxt_s = GRANT;
          rr_nxt_s    = ~rr_left_r;
          if (rr_left_r) begin
            grant_nxt_s[GNT_LEFT] = 1'b1;
          end else begin
            grant_nxt_s[GNT_RIGHT] = 1'b1;
          end
        end else if (left_s) begin
          state_nxt_s           = GRANT;
          grant_nxt_s[GNT_LEFT] = 1'b1;
        end else if (right_s) begin
          state_nxt_s            = GRANT;
          grant_nxt_s[GNT_RIGHT] = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      GRANT, DWELL: begin
        if (emerg_s && !grant_r[GNT_EMERG]) begin
          // preemption ignores dwell and restarts pacing from zero
          state_nxt_s            = GRANT;
          grant_nxt_s            = 3'b000;
          grant_nxt_s[GNT_EMERG] = 1'b1;
          presc_nxt_s            = '0;
          dwell_nxt_s            = '0;
        end else begin
          presc_nxt_s = wrap_s ? '0 : presc_r + PW'(1);
          if (wrap_s && (dwell_r != DWELL_MAX)) begin
            dwell_nxt_s = dwell_r + DW'(1);
          end else begin
            dwell_nxt_s = dwell_r;
          end
          if (own_req_s) begin
            state_nxt_s = GRANT;
          end else if (dwell_r == DWELL_MAX) begin
            state_nxt_s = IDLE;
            grant_nxt_s = 3'b000;
            presc_nxt_s = '0;
            dwell_nxt_s = '0;
          end else begin
            state_nxt_s = DWELL;
          end
          step_nxt_s = wrap_s && (state_nxt_s != IDLE);
        end
      end

      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = 3'b000;
        presc_nxt_s = '0;
        dwell_nxt_s = '0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      grant_r   <= 3'b000;
      presc_r   <= '0;
      dwell_r   <= '0;
      rr_left_r <= 1'b1;
      step_r    <= 1'b0;
      mode_r    <= MODE_HAZ;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      grant_r   <= grant_nxt_s;
      presc_r   <= presc_nxt_s;
      dwell_r   <= dwell_nxt_s;
      rr_left_r <= rr_nxt_s;
      step_r    <= step_nxt_s;
      mode_r    <= mode_of(grant_nxt_s);
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  assign mode  = mode_r;
  assign step  = step_r;
  assign grant = grant_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_hazard_mode_sched.sv
// Scoreboard bench for hazard_mode_sched (TICK_DIV=4, MIN_DWELL=2): the driver queues
// hand-computed output events; the monitor pops one per grant change or step pulse.
module tb_hazard_mode_sched;

  logic       clk;
  logic       reset;
  logic       req_emerg;
  logic       req_left;
  logic       req_right;
  logic [1:0] mode;
  logic       step;
  logic [2:0] grant;
  logic       busy;

  typedef struct {
    int         cyc;
    logic [2:0] grant;
    logic [1:0] mode;
    logic       step;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  hazard_mode_sched #(.TICK_DIV(4), .MIN_DWELL(2)) dut (
    .clk(clk), .reset(reset), .req_emerg(req_emerg), .req_left(req_left),
    .req_right(req_right), .mode(mode), .step(step), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: cycle %0d got %0d want %0d", nm, cyc, act, want);
    end
  endtask

  task automatic push(input int c, input logic [2:0] g, input logic [1:0] m, input logic s);
    ev_t e;
    e.cyc = c;
    e.grant = g;
    e.mode = m;
    e.step = s;
    exp_q.push_back(e);
  endtask

  // Returns #1 after the posedge that brings the edge count to e.
  task automatic wait_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each output event.
  initial begin
    logic [2:0] prev_g;
    logic       prev_step;
    ev_t        e;
    prev_g = 3'b000;
    prev_step = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_state", {25'd0, grant, mode, step, busy}, 32'd0);
        prev_g = 3'b000;
        prev_step = 1'b0;
      end else begin
        chk("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
        chk("busy_is_or_grant", {31'd0, busy}, {31'd0, |grant});
        chk("step_single_cycle", {31'd0, prev_step & step}, 32'd0);
        chk("step_not_in_idle", {31'd0, step & ~busy}, 32'd0);
        if ((grant != prev_g) || step) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: cycle %0d grant=%b mode=%b step=%b, none expected",
                     cyc, grant, mode, step);
          end else begin
            e = exp_q.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_grant", {29'd0, grant}, {29'd0, e.grant});
            chk("ev_mode", {30'd0, mode}, {30'd0, e.mode});
            chk("ev_step", {31'd0, step}, {31'd0, e.step});
          end
        end
        prev_g = grant;
        prev_step = step;
      end
    end
  end

  // Driver: directed stimulus with the expected events for each phase.
  initial begin
    reset = 1'b1;
    req_emerg = 1'b0;
    req_left = 1'b0;
    req_right = 1'b0;
    wait_to(3);
    reset = 1'b0;

    // single left request, held past dwell, drop lands on a suppressed step
    wait_to(23);
    req_left = 1'b1;
    push(26, 3'b010, 2'b01, 1'b0);
    push(30, 3'b010, 2'b01, 1'b1);
    push(34, 3'b010, 2'b01, 1'b1);
    wait_to(35);
    req_left = 1'b0;
    push(38, 3'b000, 2'b00, 1'b0);

    // right dropped after one step: DWELL until the second step
    wait_to(40);
    req_right = 1'b1;
    push(43, 3'b001, 2'b10, 1'b0);
    push(47, 3'b001, 2'b10, 1'b1);
    wait_to(47);
    req_right = 1'b0;
    push(51, 3'b001, 2'b10, 1'b1);
    push(52, 3'b000, 2'b00, 1'b0);

    // simultaneous left+right twice: round robin left then right
    wait_to(55);
    req_left = 1'b1;
    req_right = 1'b1;
    push(58, 3'b010, 2'b01, 1'b0);
    push(62, 3'b010, 2'b01, 1'b1);
    push(66, 3'b010, 2'b01, 1'b1);
    wait_to(65);
    req_left = 1'b0;
    req_right = 1'b0;
    push(68, 3'b000, 2'b00, 1'b0);
    wait_to(70);
    req_left = 1'b1;
    req_right = 1'b1;
    push(73, 3'b001, 2'b10, 1'b0);
    wait_to(74);
    req_left = 1'b0;
    req_right = 1'b0;
    push(77, 3'b001, 2'b10, 1'b1);
    push(81, 3'b001, 2'b10, 1'b1);
    push(82, 3'b000, 2'b00, 1'b0);

    // emergency preempts left at dwell 1; left waits for one IDLE cycle
    wait_to(84);
    req_left = 1'b1;
    push(87, 3'b010, 2'b01, 1'b0);
    push(91, 3'b010, 2'b01, 1'b1);
    wait_to(91);
    req_emerg = 1'b1;
    push(94, 3'b100, 2'b00, 1'b0);
    push(98, 3'b100, 2'b00, 1'b1);
    wait_to(99);
    req_emerg = 1'b0;
    push(102, 3'b100, 2'b00, 1'b1);
    push(103, 3'b000, 2'b00, 1'b0);
    push(104, 3'b010, 2'b01, 1'b0);
    push(108, 3'b010, 2'b01, 1'b1);

    // short drop in DWELL then re-request: dwell count kept, next drop goes to IDLE
    wait_to(108);
    req_left = 1'b0;
    wait_to(109);
    req_left = 1'b1;
    push(112, 3'b010, 2'b01, 1'b1);
    wait_to(113);
    req_left = 1'b0;
    push(116, 3'b000, 2'b00, 1'b0);

    // reset in the middle of a right grant, then 20 quiet cycles
    wait_to(118);
    req_right = 1'b1;
    push(121, 3'b001, 2'b10, 1'b0);
    push(125, 3'b001, 2'b10, 1'b1);
    wait_to(127);
    reset = 1'b1;
    req_right = 1'b0;
    wait_to(130);
    reset = 1'b0;
    wait_to(150);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
